// File: rtl/sdcmdtx_if.sv
// CMD-line transmitter bus: ROM fetch, packet control, CMD pin and response results.
interface sdcmdtx_if;
  logic        start;
  logic        rspen;
  logic        rspnocrc;
  logic [7:0]  SDPKTDATA;
  logic        cmdin;
  logic [4:0]  PTCMDPNTR;
  logic        cmdout;
  logic        cmdoe;
  logic        busy;
  logic        tcvcptdone;
  logic        crcerr;
  logic        timeout;
  logic [5:0]  RSPIDX;
  logic [31:0] RSPDATA;

  modport master (
    output start, rspen, rspnocrc, SDPKTDATA, cmdin,
    input  PTCMDPNTR, cmdout, cmdoe, busy, tcvcptdone, crcerr, timeout, RSPIDX, RSPDATA
  );
  modport slave (
    input  start, rspen, rspnocrc, SDPKTDATA, cmdin,
    output PTCMDPNTR, cmdout, cmdoe, busy, tcvcptdone, crcerr, timeout, RSPIDX, RSPDATA
  );
endinterface

// File: rtl/sdcmdtx.sv
// SD CMD-line packet serializer: 40 ROM bits + CRC7 + end bit, optional 48-bit response capture.
module sdcmdtx #(
  parameter int NCRMAX = 64,
  parameter int NCC    = 8
) (
  input logic       clk,
  input logic       reset,
  sdcmdtx_if.slave  bus
);
  typedef enum logic [3:0] {
    IDLE, FETCH, SEND, SCRC, SEND_END, WAITRSP, RECV, NCCST, DONE
  } state_t;

  localparam logic [7:0] CNT_TO  = 8'(NCRMAX - 1);
  localparam logic [7:0] CNT_NCC = 8'(NCC);

  state_t      state, state_d;
  logic [7:0]  cnt, cnt_d;
  logic [4:0]  ptr, ptr_d;
  logic [7:0]  sh, sh_d;
  logic [6:0]  crc, crc_d;
  logic [45:0] rsh, rsh_d;
  logic        cmdout, cmdout_d, cmdoe, cmdoe_d;
  logic        crcerr, crcerr_d, timeout, timeout_d;
  logic [5:0]  rspidx, rspidx_d;
  logic [31:0] rspdata, rspdata_d;
  logic        tx;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      ptr     <= '0;
      sh      <= '0;
      crc     <= '0;
      rsh     <= '0;
      cmdout  <= 1'b1;
      cmdoe   <= 1'b0;
      crcerr  <= 1'b0;
      timeout <= 1'b0;
      rspidx  <= '0;
      rspdata <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      ptr     <= ptr_d;
      sh      <= sh_d;
      crc     <= crc_d;
      rsh     <= rsh_d;
      cmdout  <= cmdout_d;
      cmdoe   <= cmdoe_d;
      crcerr  <= crcerr_d;
      timeout <= timeout_d;
      rspidx  <= rspidx_d;
      rspdata <= rspdata_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    ptr_d     = ptr;
    sh_d      = sh;
    crc_d     = crc;
    rsh_d     = rsh;
    cmdout_d  = cmdout;
    cmdoe_d   = cmdoe;
    crcerr_d  = crcerr;
    timeout_d = timeout;
    rspidx_d  = rspidx;
    rspdata_d = rspdata;
    tx        = 1'b0;
    unique case (state)
      IDLE: begin
        ptr_d    = '0;
        cmdoe_d  = 1'b0;
        cmdout_d = 1'b1;
        if (bus.start) begin
          state_d   = FETCH;
          crcerr_d  = 1'b0;
          timeout_d = 1'b0;
          crc_d     = '0;
          cnt_d     = '0;
        end
      end
      // byte 0 is already on SDPKTDATA since the pointer sat at 0 in IDLE
      FETCH: begin
        tx       = bus.SDPKTDATA[7];
        sh_d     = {bus.SDPKTDATA[6:0], 1'b0};
        ptr_d    = ptr + 5'd1;
        cmdout_d = tx;
        cmdoe_d  = 1'b1;
        crc_d    = crc7_step(crc, tx);
        cnt_d    = 8'd1;
        state_d  = SEND;
      end
      SEND: begin
        if (cnt[2:0] == 3'd0) begin
          tx    = bus.SDPKTDATA[7];
          sh_d  = {bus.SDPKTDATA[6:0], 1'b0};
          ptr_d = ptr + 5'd1;
        end else begin
          tx    = sh[7];
          sh_d  = {sh[6:0], 1'b0};
        end
        cmdout_d = tx;
        crc_d    = crc7_step(crc, tx);
        cnt_d    = cnt + 8'd1;
        if (cnt == 8'd39) begin
          cnt_d   = '0;
          state_d = SCRC;
        end
      end
      // shifting the CRC out leaves it zero for the response
      SCRC: begin
        cmdout_d = crc[6];
        crc_d    = {crc[5:0], 1'b0};
        cnt_d    = cnt + 8'd1;
        if (cnt == 8'd6) begin
          cnt_d   = '0;
          state_d = SEND_END;
        end
      end
      SEND_END: begin
        cmdout_d = 1'b1;
        crc_d    = '0;
        cnt_d    = '0;
        state_d  = bus.rspen ? WAITRSP : NCCST;
      end
      WAITRSP: begin
        cmdoe_d = 1'b0;
        if (!bus.cmdin) begin
          crc_d   = crc7_step(crc, 1'b0);
          cnt_d   = 8'd1;
          state_d = RECV;
        end else if (cnt == CNT_TO) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = NCCST;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      // rsh holds response bits 46..1; the start bit is implied
      RECV: begin
        cmdoe_d = 1'b0;
        rsh_d   = {rsh[44:0], bus.cmdin};
        if (cnt < 8'd40) crc_d = crc7_step(crc, bus.cmdin);
        cnt_d = cnt + 8'd1;
        if (cnt == 8'd47) begin
          crcerr_d  = rsh[45] | ~bus.cmdin | (~bus.rspnocrc & (crc != rsh[6:0]));
          rspidx_d  = rsh[44:39];
          rspdata_d = rsh[38:7];
          cnt_d     = '0;
          state_d   = NCCST;
        end
      end
      NCCST: begin
        cmdoe_d  = 1'b1;
        cmdout_d = 1'b1;
        if (cnt == CNT_NCC) begin
          ptr_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      DONE: begin
        cmdoe_d = 1'b0;
        ptr_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.PTCMDPNTR  = ptr;
  assign bus.cmdout     = cmdout;
  assign bus.cmdoe      = cmdoe;
  assign bus.busy       = (state != IDLE);
  assign bus.tcvcptdone = (state == DONE);
  assign bus.crcerr     = crcerr;
  assign bus.timeout    = timeout;
  assign bus.RSPIDX     = rspidx;
  assign bus.RSPDATA    = rspdata;
endmodule

// File: tb/tb_sdcmdtx.sv
// Directed bench for sdcmdtx: ROM model, card response driver, cycle-accurate checks.
module tb_sdcmdtx;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sdcmdtx_if bus();
  sdcmdtx #(.NCRMAX(64), .NCC(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [7:0] rom [0:7];
  always @(posedge clk) bus.SDPKTDATA <= rom[bus.PTCMDPNTR[2:0]];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = c[6] ^ d[i];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  logic [47:0] stream;
  int          done_cyc;
  int          pmax;
  int          oe_bad;
  logic        oe50;

  task automatic run(input logic [39:0] pkt, input logic ren, input logic nocrc,
                     input logic has_rsp, input int k, input logic [47:0] rsp, input logic poke);
    int n;
    for (int i = 0; i < 8; i++) rom[i] = (i < 5) ? pkt[39-8*i -: 8] : 8'h00;
    @(negedge clk);
    bus.rspen = ren; bus.rspnocrc = nocrc; bus.cmdin = 1'b1; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    stream = '0; done_cyc = -1; pmax = 0; oe_bad = 0; oe50 = 1'bx;
    for (int cyc = 1; cyc <= 300 && done_cyc < 0; cyc++) begin
      @(posedge clk); #1;
      if (cyc <= 48) begin
        stream[48-cyc] = bus.cmdout;
        if (bus.cmdoe !== 1'b1) oe_bad++;
      end
      if (int'(bus.PTCMDPNTR) > pmax) pmax = int'(bus.PTCMDPNTR);
      if (cyc == 50) oe50 = bus.cmdoe;
      if (bus.tcvcptdone) done_cyc = cyc;
      n = cyc + 1;
      bus.cmdin = (has_rsp && n >= 49 + k && n <= 96 + k) ? rsp[47-(n-49-k)] : 1'b1;
      bus.start = poke && (cyc == 10 || cyc == 40);
    end
    bus.cmdin = 1'b1;
    bus.start = 1'b0;
  endtask

  logic [47:0] rsp55;
  int pulses;

  initial begin
    reset = 1'b0;
    bus.start = 1'b0; bus.rspen = 1'b0; bus.rspnocrc = 1'b0; bus.cmdin = 1'b1;
    for (int i = 0; i < 8; i++) rom[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",   bus.busy, 0);
    chk("rst_cmdoe",  bus.cmdoe, 0);
    chk("rst_cmdout", bus.cmdout, 1);
    chk("rst_ptr",    bus.PTCMDPNTR, 0);
    chk("rst_done",   bus.tcvcptdone, 0);
    chk("rst_flags",  {bus.crcerr, bus.timeout}, 0);
    chk("rst_rsp",    {bus.RSPIDX, bus.RSPDATA}, 0);
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);

    // CMD0, no response
    run(40'h40_00_00_00_00, 0, 0, 0, 0, 48'h0, 0);
    chk("cmd0_stream", stream, 48'h40_00_00_00_00_95);
    chk("cmd0_done",   done_cyc, 57);
    chk("cmd0_pmax",   pmax, 5);
    chk("cmd0_oe",     oe_bad, 0);
    repeat (2) @(negedge clk);
    chk("cmd0_ptr0",   bus.PTCMDPNTR, 0);
    chk("cmd0_idle",   bus.busy, 0);

    // CMD8 with R7 reply at k=2 (reply CRC7 = 0x09 -> trailer 0x13)
    run(40'h48_00_00_01_AA, 1, 0, 1, 2, 48'h08_00_00_01_AA_13, 0);
    chk("cmd8_stream", stream, 48'h48_00_00_01_AA_87);
    chk("cmd8_done",   done_cyc, 107);
    chk("cmd8_oe50",   oe50, 0);
    chk("cmd8_idx",    bus.RSPIDX, 6'h08);
    chk("cmd8_data",   bus.RSPDATA, 32'h0000_01AA);
    chk("cmd8_crcerr", bus.crcerr, 0);
    chk("cmd8_tmo",    bus.timeout, 0);
    repeat (2) @(negedge clk);

    // CMD55 with corrupted reply CRC at k=0
    rsp55 = {40'h37_00_00_01_20, crc7(40'h37_00_00_01_20) ^ 7'h01, 1'b1};
    run(40'h77_00_00_00_00, 1, 0, 1, 0, rsp55, 0);
    chk("cmd55_stream", stream, 48'h77_00_00_00_00_65);
    chk("cmd55_done",   done_cyc, 105);
    chk("cmd55_crcerr", bus.crcerr, 1);
    chk("cmd55_idx",    bus.RSPIDX, 6'h37);
    chk("cmd55_data",   bus.RSPDATA, 32'h0000_0120);
    repeat (2) @(negedge clk);

    // no start bit ever seen
    run(40'h48_00_00_01_AA, 1, 0, 0, 0, 48'h0, 0);
    chk("tmo_done",   done_cyc, 121);
    chk("tmo_flag",   bus.timeout, 1);
    chk("tmo_crcerr", bus.crcerr, 0);
    repeat (2) @(negedge clk);

    // R3 reply, CRC field all ones, check skipped
    run(40'h69_40_FF_80_00, 1, 1, 1, 5, 48'h3F_00_FF_80_00_FF, 0);
    chk("r3_cmd",    stream[47:8], 40'h69_40_FF_80_00);
    chk("r3_done",   done_cyc, 110);
    chk("r3_crcerr", bus.crcerr, 0);
    chk("r3_tmo",    bus.timeout, 0);
    chk("r3_idx",    bus.RSPIDX, 6'h3F);
    chk("r3_data",   bus.RSPDATA, 32'h00FF_8000);
    repeat (2) @(negedge clk);

    // reset in the middle of a command
    for (int i = 0; i < 8; i++) rom[i] = 8'h00;
    rom[0] = 8'h40;
    @(negedge clk); bus.rspen = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk); bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("mid_busy", bus.busy, 1);
    @(negedge clk) reset = 1'b0;
    #1;
    chk("mid_cmdoe",  bus.cmdoe, 0);
    chk("mid_cmdout", bus.cmdout, 1);
    chk("mid_busy0",  bus.busy, 0);
    chk("mid_ptr",    bus.PTCMDPNTR, 0);
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (bus.tcvcptdone) pulses++;
      if (i == 3) reset = 1'b1;
    end
    chk("mid_nodone", pulses, 0);
    chk("mid_idle",   bus.busy, 0);

    // fresh command after reset, start pulses while busy
    run(40'h40_00_00_00_00, 0, 0, 0, 0, 48'h0, 1);
    chk("post_stream", stream, 48'h40_00_00_00_00_95);
    chk("post_done",   done_cyc, 57);
    repeat (3) @(negedge clk);
    chk("post_idle",   bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
